// File: rtl/ofdm_tx_cr_top.sv
// OFDM transmit carrier mapper: QPSK bit pairs + allocation RAM -> natural-order subcarrier stream.
// Config port loads the standard and per-symbol allocation bitmaps; a frame runs once per start request.

// QPSK mapper: combinational, zero latency; acceptance is decided downstream and passed straight back.
module qpsk_mod #(
    parameter logic signed [15:0] AMP = 16'sd23170
) (
    input  logic [1:0]  DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    input  logic        ACK_I,
    output logic [31:0] DAT_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    output logic        ACK_O
);
    always_comb begin
        DAT_O[15:0]  = DAT_I[0] ? -AMP : AMP;
        DAT_O[31:16] = DAT_I[1] ? -AMP : AMP;
    end
    assign WE_O  = WE_I;
    assign STB_O = STB_I;
    assign CYC_O = CYC_I;
    assign ACK_O = ACK_I;
endmodule

// Slot mapper: picks null/pilot/data word for the current subcarrier; combinational, stalls on ACK_I low.
module pilots_insert #(
    parameter logic signed [15:0] AMP = 16'sd23170
) (
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    input  logic        ACK_I,
    input  logic        en_i,
    input  logic        frame_i,
    input  logic        slot_on_i,
    input  logic        slot_pilot_i,
    output logic [31:0] DAT_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    output logic        ACK_O
);
    logic slot_data;

    always_comb begin
        slot_data = slot_on_i & ~slot_pilot_i;
        ACK_O     = en_i & slot_data & CYC_I & STB_I & WE_I & ACK_I;
        // An exhausted source (CYC_I low) lets data slots advance as zeros.
        STB_O     = en_i & ACK_I & (~slot_data | ~CYC_I | (STB_I & WE_I));
        if (!slot_on_i)        DAT_O = '0;
        else if (slot_pilot_i) DAT_O = {16'h0000, AMP};
        else if (CYC_I)        DAT_O = DAT_I;
        else                   DAT_O = '0;
    end
    assign WE_O  = STB_O;
    assign CYC_O = frame_i;
endmodule

// Output register toward the IFFT: one-cycle latency; holds the word until ACK_I, free when empty or draining.
module ifft_mod (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    input  logic        ACK_I,
    output logic [31:0] DAT_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    output logic        ACK_O
);
    logic [31:0] dat_q, dat_d;
    logic        stb_q, stb_d;

    always_comb begin
        ACK_O = ~stb_q | ACK_I;
        dat_d = dat_q;
        stb_d = stb_q;
        if (ACK_O) begin
            stb_d = STB_I & WE_I;
            if (STB_I & WE_I) dat_d = DAT_I;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            dat_q <= '0;
            stb_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            stb_q <= stb_d;
        end
    end

    assign DAT_O = dat_q;
    assign STB_O = stb_q;
    assign WE_O  = stb_q;
    assign CYC_O = CYC_I;
endmodule

module ofdm_tx_cr_top #(
    parameter logic signed [15:0] AMP         = 16'sd23170,
    parameter int                 ALLOC_DEPTH = 512
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] CFG_DAT_I,
    input  logic [1:0]  CFG_ADR_I,
    input  logic        CFG_WE_I,
    input  logic        CFG_STB_I,
    output logic        CFG_ACK_O,
    input  logic [1:0]  DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic        ACK_I
);
    localparam int AW = $clog2(ALLOC_DEPTH);
    localparam int CW = $clog2(ALLOC_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      std_q, std_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   wcnt_q, wcnt_d, sym_q, sym_d, nsym;
    logic [11:0]     k_q, k_d, nfft_m1;
    logic [7:0]      nw;
    logic            last_q, last_d, cyc_q, cyc_d, cfg_ack_q, cfg_ack_d;
    logic [31:0]     ram [ALLOC_DEPTH];
    logic [31:0]     rd_lin, rd_word, map_dat, slot_dat;
    logic            cfg_wr, slot_on, slot_pilot, run_en, xfer;
    logic            map_we, map_stb, map_cyc, map_ack;
    logic            slot_we, slot_stb, slot_cyc, slot_ack, out_free;

    always_comb begin
        case (std_q)
            2'd0:    begin nfft_m1 = 12'd127;  nw = 8'd4;   nsym = wcnt_q >> 2; end
            2'd1:    begin nfft_m1 = 12'd511;  nw = 8'd16;  nsym = wcnt_q >> 4; end
            2'd2:    begin nfft_m1 = 12'd4095; nw = 8'd128; nsym = wcnt_q >> 7; end
            default: begin nfft_m1 = 12'd0;    nw = 8'd0;   nsym = '0;          end
        endcase
        rd_lin     = 32'(sym_q) * 32'(nw) + 32'(k_q[11:5]);
        rd_word    = ram[AW'(rd_lin % 32'(ALLOC_DEPTH))];
        slot_on    = rd_word[k_q[4:0]];
        slot_pilot = (k_q[3:0] == 4'd8);
        // Once the final slot is loaded nothing more is consumed or issued.
        run_en     = (state_q == RUN) && !last_q;
        cfg_wr     = CFG_STB_I & CFG_WE_I & (state_q != RUN);
        xfer       = STB_O & ACK_I;
    end

    always_comb begin
        state_d   = state_q;
        std_d     = std_q;
        wptr_d    = wptr_q;
        wcnt_d    = wcnt_q;
        sym_d     = sym_q;
        k_d       = k_q;
        last_d    = last_q;
        cyc_d     = cyc_q;
        cfg_ack_d = cfg_wr;
        if (cfg_wr) begin
            case (CFG_ADR_I)
                2'd0: begin
                    std_d  = CFG_DAT_I[1:0];
                    wptr_d = '0;
                    wcnt_d = '0;
                end
                2'd1: begin
                    wptr_d = (wptr_q == AW'(ALLOC_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                    if (wcnt_q != CW'(ALLOC_DEPTH)) wcnt_d = wcnt_q + 1'b1;
                end
                default: ;
            endcase
        end
        case (state_q)
            IDLE: begin
                // A config write in flight defers the start so its ack never lands inside RUN.
                if (!cfg_wr && CYC_I && STB_I && nsym != '0 && std_q != 2'd3) begin
                    state_d = RUN;
                    cyc_d   = 1'b1;
                    k_d     = '0;
                    sym_d   = '0;
                    last_d  = 1'b0;
                end
            end
            RUN: begin
                if (last_q) begin
                    if (xfer) begin
                        state_d = DONE;
                        cyc_d   = 1'b0;
                        last_d  = 1'b0;
                    end
                end else if (slot_stb) begin
                    if (k_q == nfft_m1) begin
                        k_d = '0;
                        if (sym_q == nsym - 1'b1) begin
                            sym_d  = '0;
                            last_d = 1'b1;
                        end else begin
                            sym_d = sym_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            std_q     <= '0;
            wptr_q    <= '0;
            wcnt_q    <= '0;
            sym_q     <= '0;
            k_q       <= '0;
            last_q    <= 1'b0;
            cyc_q     <= 1'b0;
            cfg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            std_q     <= std_d;
            wptr_q    <= wptr_d;
            wcnt_q    <= wcnt_d;
            sym_q     <= sym_d;
            k_q       <= k_d;
            last_q    <= last_d;
            cyc_q     <= cyc_d;
            cfg_ack_q <= cfg_ack_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (cfg_wr && CFG_ADR_I == 2'd1) ram[wptr_q] <= CFG_DAT_I;
    end

    assign CFG_ACK_O = cfg_ack_q;

    qpsk_mod #(.AMP(AMP)) QPSK_Mod_Ins (
        .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I), .ACK_I(slot_ack),
        .DAT_O(map_dat), .WE_O(map_we), .STB_O(map_stb), .CYC_O(map_cyc), .ACK_O(map_ack)
    );

    pilots_insert #(.AMP(AMP)) Pilots_Insert_Ins (
        .DAT_I(map_dat), .WE_I(map_we), .STB_I(map_stb), .CYC_I(map_cyc), .ACK_I(out_free),
        .en_i(run_en), .frame_i(cyc_q), .slot_on_i(slot_on), .slot_pilot_i(slot_pilot),
        .DAT_O(slot_dat), .WE_O(slot_we), .STB_O(slot_stb), .CYC_O(slot_cyc), .ACK_O(slot_ack)
    );

    ifft_mod IFFT_Mod_Ins (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .DAT_I(slot_dat), .WE_I(slot_we), .STB_I(slot_stb), .CYC_I(slot_cyc), .ACK_I(ACK_I),
        .DAT_O(DAT_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_O(out_free)
    );

    assign ACK_O = map_ack;
endmodule

// File: tb/tb_ofdm_tx_cr_top.sv
// Directed bench for ofdm_tx_cr_top: config load, full frames at each standard, backpressure, reset abort.
module tb_ofdm_tx_cr_top;
    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [31:0] CFG_DAT_I = '0;
    logic [1:0]  CFG_ADR_I = '0;
    logic        CFG_WE_I = 1'b0, CFG_STB_I = 1'b0, CFG_ACK_O;
    logic [1:0]  DAT_I = '0;
    logic        WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0, ACK_O;
    logic [31:0] DAT_O;
    logic        WE_O, STB_O, CYC_O;
    logic        ACK_I = 1'b0;

    ofdm_tx_cr_top dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .CFG_DAT_I(CFG_DAT_I), .CFG_ADR_I(CFG_ADR_I), .CFG_WE_I(CFG_WE_I),
        .CFG_STB_I(CFG_STB_I), .CFG_ACK_O(CFG_ACK_O),
        .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I), .ACK_O(ACK_O),
        .DAT_O(DAT_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  std_m;
    logic [31:0] alloc_m[$];
    logic [1:0]  src[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // +23170 = 16'h5A82, -23170 = 16'hA57E
    function automatic logic [31:0] qpsk(input logic [1:0] d);
        logic [15:0] re, im;
        re = d[0] ? 16'hA57E : 16'h5A82;
        im = d[1] ? 16'hA57E : 16'h5A82;
        return {im, re};
    endfunction

    task automatic cfg_wr(input logic [1:0] adr, input logic [31:0] dat);
        @(negedge CLK_I);
        CFG_STB_I = 1'b1; CFG_WE_I = 1'b1; CFG_ADR_I = adr; CFG_DAT_I = dat;
        @(negedge CLK_I);
        CFG_STB_I = 1'b0; CFG_WE_I = 1'b0;
        chk("cfg_ack", CFG_ACK_O, 1);
        if (adr == 2'd0) begin
            alloc_m.delete();
            std_m = dat[1:0];
        end else if (adr == 2'd1) begin
            alloc_m.push_back(dat);
        end
    endtask

    task automatic cfg_fill(input int n, input logic [31:0] dat);
        for (int i = 0; i < n; i++) cfg_wr(2'd1, dat);
    endtask

    task automatic run_frame(input string tag, input bit rnd_ack);
        int nfft, nw, nsym, si, cyc, viol, cyc_lo, consumed;
        nfft = (std_m == 2'd0) ? 128 : (std_m == 2'd1) ? 512 : 4096;
        nw   = nfft / 32;
        nsym = alloc_m.size() / nw;
        exp_q.delete();
        si = 0;
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < nfft; k++) begin
                logic [31:0] w;
                w = alloc_m[s * nw + k / 32];
                if (!w[k % 32])          exp_q.push_back(32'h0);
                else if (k % 16 == 8)    exp_q.push_back(32'h0000_5A82);
                else if (si < src.size()) begin
                    exp_q.push_back(qpsk(src[si]));
                    si++;
                end else                 exp_q.push_back(32'h0);
            end
        end
        got_q.delete();
        consumed = 0; viol = 0; cyc_lo = 0; cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 20000) begin
            @(negedge CLK_I);
            ACK_I = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            CYC_I = (consumed < src.size());
            STB_I = CYC_I;
            WE_I  = 1'b1;
            DAT_I = CYC_I ? src[consumed] : 2'b00;
            #1;
            if (STB_O && ACK_I) begin
                got_q.push_back(DAT_O);
                if (!CYC_O) cyc_lo++;
            end
            if (ACK_O && STB_O && !ACK_I) viol++;
            if (ACK_O) consumed++;
            cyc++;
        end
        @(negedge CLK_I);
        CYC_I = 1'b0; STB_I = 1'b0; ACK_I = 1'b1;
        #1;
        chk({tag, "_cyc_fall"}, CYC_O, 0);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_consumed"}, consumed, si);
        chk({tag, "_cyc_hold"}, cyc_lo, 0);
        chk({tag, "_ack_viol"}, viol, 0);
        repeat (3) @(negedge CLK_I);
        chk({tag, "_idle_stb"}, STB_O, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hits;
        RST_I = 1'b1;
        repeat (2) @(negedge CLK_I);
        chk("rst_dat", DAT_O, 0);
        chk("rst_stb", STB_O, 0);
        chk("rst_we", WE_O, 0);
        chk("rst_cyc", CYC_O, 0);
        chk("rst_ack", ACK_O, 0);
        chk("rst_cfg_ack", CFG_ACK_O, 0);
        RST_I = 1'b0;

        // Frame A: all subcarriers allocated, constant 2'b00 input
        cfg_wr(2'd0, 32'd0);
        cfg_fill(4, 32'hFFFF_FFFF);
        @(negedge CLK_I);
        chk("cfg_ack_low", CFG_ACK_O, 0);
        src.delete();
        for (int i = 0; i < 120; i++) src.push_back(2'b00);
        run_frame("A", 1'b0);
        chk("A_pilot8", got_q[8], 32'h0000_5A82);
        chk("A_data0", got_q[0], 32'h5A82_5A82);

        // Frame B: 7 words -> one symbol, input runs out early, random backpressure
        cfg_wr(2'd0, 32'd0);
        cfg_fill(7, 32'hFFFF_FFFF);
        src.delete();
        src.push_back(2'b11);
        src.push_back(2'b01);
        for (int i = 2; i < 100; i++) src.push_back(2'(i));
        run_frame("B", 1'b1);
        chk("B_qpsk11", got_q[0], 32'hA57E_A57E);
        chk("B_qpsk01", got_q[1], 32'h5A82_A57E);
        chk("B_qpsk10", got_q[2], 32'hA57E_5A82);
        chk("B_exhaust", got_q[127], 32'h0);

        // Frame C: only k=0..3 allocated
        cfg_wr(2'd0, 32'd0);
        cfg_wr(2'd1, 32'h0000_000F);
        cfg_fill(3, 32'h0);
        src.delete();
        src.push_back(2'b11); src.push_back(2'b01); src.push_back(2'b10); src.push_back(2'b00);
        for (int i = 0; i < 6; i++) src.push_back(2'b11);
        run_frame("C", 1'b0);
        chk("C_k3", got_q[3], 32'h5A82_5A82);
        chk("C_k4", got_q[4], 32'h0);

        // Frame D: two symbols, second one sparse with a pilot and band-edge data
        cfg_wr(2'd0, 32'd0);
        cfg_fill(4, 32'h0);
        cfg_wr(2'd1, 32'h0000_0103);
        cfg_fill(3, 32'h8000_0000);
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(2'(i + 1));
        run_frame("D", 1'b1);
        chk("D_s1_pilot", got_q[128 + 8], 32'h0000_5A82);

        // NFFT=512
        cfg_wr(2'd0, 32'd1);
        cfg_fill(16, 32'h0000_0101);
        src.delete();
        for (int i = 0; i < 20; i++) src.push_back(2'(3 - i));
        run_frame("S1", 1'b1);

        // NFFT=4096, only the last subcarrier allocated
        cfg_wr(2'd0, 32'd2);
        cfg_fill(127, 32'h0);
        cfg_wr(2'd1, 32'h8000_0000);
        src.delete();
        src.push_back(2'b10); src.push_back(2'b11); src.push_back(2'b01);
        run_frame("S2", 1'b0);
        chk("S2_last", got_q[4095], 32'hA57E_5A82);

        // Reserved standard and empty allocation never start a frame
        cfg_wr(2'd0, 32'd3);
        cfg_fill(4, 32'hFFFF_FFFF);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_I);
            CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1;
            #1;
            if (CYC_O || STB_O || ACK_O) hits++;
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        chk("std3_idle", hits, 0);
        cfg_wr(2'd0, 32'd0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_I);
            CYC_I = 1'b1; STB_I = 1'b1;
            #1;
            if (CYC_O || STB_O || ACK_O) hits++;
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        chk("empty_idle", hits, 0);

        // Reset in the middle of a frame
        cfg_fill(4, 32'hFFFF_FFFF);
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = 2'b11; ACK_I = 1'b1;
        repeat (30) @(negedge CLK_I);
        chk("mid_cyc", CYC_O, 1);
        chk("mid_stb", STB_O, 1);
        RST_I = 1'b1;
        @(negedge CLK_I);
        chk("abort_dat", DAT_O, 0);
        chk("abort_stb", STB_O, 0);
        chk("abort_we", WE_O, 0);
        chk("abort_cyc", CYC_O, 0);
        chk("abort_ack", ACK_O, 0);
        chk("abort_cfg_ack", CFG_ACK_O, 0);
        RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
        repeat (2) @(negedge CLK_I);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
